commit_trace_capture: RTL and testbench
=======================================

# commit_trace_capture

Captures one commit record per clock from the single-cycle Mips core's debug outputs (PC, instruction, register write data) into an internal FIFO. A host or testbench drains the FIFO through a valid/ready port. The block sits directly downstream of the core's debug port. It replaces ad-hoc `$monitor` tracing with a synthesizable, bounded trace window. Start, stop and PC-match controls define the window; overflow is detected and counted, never silently lost.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `MAX_RECORDS`, 256: records pushed before auto-stop; 0 disables the limit.

Ports:
- `clk`  input  1  single clock, shared with the Mips core.
- `reset`  input  1  asynchronous, active-low; one clock domain.
- `start`  input  1  one-cycle pulse; arms capture.
- `stop`  input  1  one-cycle pulse; ends capture.
- `stopPcEnable`  input  1  enables PC-match stop.
- `stopPc`  input  32  PC that ends capture when matched.
- `pc`  input  32  core PC of the committing instruction.
- `instruction`  input  32  core instruction.
- `regWriteData`  input  32  core register-file write data.
- `outValid`  output  1  head record available.
- `outReady`  input  1  consumer accepts the head record.
- `outRecord`  output  96  {pc, instruction, regWriteData}, with pc in the MSBs.
- `busy`  output  1  state is CAPTURE.
- `done`  output  1  state is DONE.
- `overflow`  output  1  sticky; at least one record was dropped.
- `dropCount`  output  16  dropped records, saturating at 16'hFFFF.
- `recordCount`  output  16  records accepted this window, saturating.

## Operation
States: IDLE, CAPTURE, DONE.
- IDLE → CAPTURE on `start`. On that transition: clear `overflow`, `dropCount` and `recordCount`. FIFO contents are kept.
- CAPTURE: every clock is one push attempt, sampling `pc`, `instruction` and `regWriteData`.
- CAPTURE → DONE on the first of the following. In every case the current cycle's record is still pushed:
  - `stop`;
  - `stopPcEnable` is set and `pc == stopPc`;
  - `recordCount` reaches `MAX_RECORDS` after the push (when `MAX_RECORDS` is nonzero).
- DONE → CAPTURE on `start`, with the same clears as above. DONE → IDLE never happens except by reset.
- Push outcome:
  - FIFO not full, or full with a pop in the same cycle: record accepted, `recordCount` +1.
  - Otherwise: record dropped, `overflow` set, `dropCount` +1 (saturating).
- Pop when `outValid && outReady`. Popping is independent of state, so the FIFO drains in any state.
- `start` during CAPTURE is ignored. `start` and `stop` in the same IDLE cycle: start wins; the next cycle is CAPTURE with no stop pending.

## Timing
- Reset values: state IDLE, FIFO empty, `outValid` 0, `outRecord` 0, `busy` 0, `done` 0, `overflow` 0, `dropCount` 0, `recordCount` 0.
- Reset asserted mid-capture or mid-drain flushes everything asynchronously. Capture resumes only after a later `start`.
- `start` sampled at edge N: state is CAPTURE after N. The first record is sampled at edge N+1.
- Push-to-visible latency is 1 cycle. A record pushed into an empty FIFO at edge N gives `outValid` = 1 after edge N. There is no combinational bypass.
- `outRecord` is the registered or array head. It is stable while `outValid && !outReady`.
- `busy` and `done` are decoded from the state register.
- Pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal. Wrap-around is natural modulo.

## Structure
- Package `trace_pkg` holds:
  - state enum (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2);
  - `RECORD_W`=96 and field offset constants;
  - the saturation max 16'hFFFF.
- Sub-module `trace_fifo` is a synchronous FIFO parameterized by width and depth. It provides push, pop, full, empty and head outputs. The top level holds the FSM, counters and drop logic.

## Test plan
- Reset, then `start`; core runs with PC 0,4,8,…; `outReady`=1, `MAX_RECORDS`=4 → exactly 4 records with pc 0,4,8,12, then `done`=1, `dropCount`=0.
- `outReady`=0, `DEPTH`=16, `MAX_RECORDS`=0; capture 20 cycles, then `stop` → `recordCount`=16, `dropCount`=4 (approximate), `overflow`=1. Draining yields the first 16 records in order; verify the exact counts against the stop cycle.
- FIFO full, `outReady`=1 continuously during capture → no drops. Simultaneous push and pop is accepted at full.
- `stopPcEnable`=1, `stopPc`=32'h10 → the last record has pc 32'h10 and the state is DONE on the next cycle.
- Assert `reset` low mid-capture with 5 records queued → `outValid`=0 immediately and all counters 0. After release, no capture occurs until `start`.
- `start` and `stop` in the same IDLE cycle → CAPTURE is entered and the capture continues.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace capture block.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } traceState_e;

  localparam int unsigned FIELD_W   = 32;
  localparam int unsigned RECORD_W  = 96;
  localparam int unsigned PC_LSB    = 64;
  localparam int unsigned INSTR_LSB = 32;
  localparam int unsigned WDATA_LSB = 0;
  localparam int unsigned CNT_W     = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Increment that sticks at the counter maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read straight from the array.
module trace_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wrEn;
  logic             rdEn;

  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty = (wrPtr == rdPtr);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign wrEn  = push && (!full || pop);
  assign rdEn  = pop && !empty;
  assign head  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PW'(1);
      if (rdEn) rdPtr <= rdPtr + PW'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else if (wrEn) begin
      mem[wrPtr[AW-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/commit_trace_capture.sv
// Captures one commit record per clock from the core debug port into a drainable FIFO.
module commit_trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_RECORDS = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                stopPcEnable,
  input  logic [FIELD_W-1:0]  stopPc,
  input  logic [FIELD_W-1:0]  pc,
  input  logic [FIELD_W-1:0]  instruction,
  input  logic [FIELD_W-1:0]  regWriteData,
  output logic                outValid,
  input  logic                outReady,
  output logic [RECORD_W-1:0] outRecord,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNT_W-1:0]    dropCount,
  output logic [CNT_W-1:0]    recordCount
);

  localparam logic [CNT_W-1:0] MAX_REC  = CNT_W'(MAX_RECORDS);
  localparam logic             LIMIT_ON = (MAX_RECORDS != 0);

  traceState_e          state;
  traceState_e          nextState;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 popFire;
  logic                 pushAttempt;
  logic                 pushAccept;
  logic                 startFire;
  logic                 pcHit;
  logic                 limitHit;
  logic [RECORD_W-1:0]  pushData;

  assign outValid    = !fifoEmpty;
  assign popFire     = outValid && outReady;
  assign pushAttempt = (state == CAPTURE);
  assign pushAccept  = pushAttempt && (!fifoFull || popFire);
  assign startFire   = start && (state != CAPTURE);
  assign pcHit       = stopPcEnable && (pc == stopPc);
  assign limitHit    = LIMIT_ON && pushAccept && (satInc(recordCount) == MAX_REC);
  assign busy        = (state == CAPTURE);
  assign done        = (state == DONE);

  always_comb begin
    pushData = '0;
    pushData[PC_LSB    +: FIELD_W] = pc;
    pushData[INSTR_LSB +: FIELD_W] = instruction;
    pushData[WDATA_LSB +: FIELD_W] = regWriteData;
  end

  trace_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushAttempt),
    .pushData (pushData),
    .pop      (popFire),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (outRecord)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Stop conditions all act after the current cycle's push attempt.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = CAPTURE;
      CAPTURE: if (stop || pcHit || limitHit) nextState = DONE;
      DONE:    if (start) nextState = CAPTURE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      dropCount   <= '0;
      recordCount <= '0;
    end else if (startFire) begin
      overflow    <= 1'b0;
      dropCount   <= '0;
      recordCount <= '0;
    end else if (pushAttempt) begin
      if (pushAccept) begin
        recordCount <= satInc(recordCount);
      end else begin
        overflow  <= 1'b1;
        dropCount <= satInc(dropCount);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_capture.sv
// Directed bench for commit_trace_capture with a queue-based reference model.
module tb_commit_trace_capture;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXR  = 20;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        stopPcEnable;
  logic [31:0] stopPc;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] regWriteData;
  logic        outValid;
  logic        outReady;
  logic [95:0] outRecord;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] dropCount;
  logic [15:0] recordCount;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 capture, 2 done.
  logic [95:0] mq[$];
  logic [31:0] drained[$];
  int          mState = 0;
  int          mRec   = 0;
  int          mDrop  = 0;
  bit          mOvf   = 0;
  bit          mPop;
  bit          mRoom;

  commit_trace_capture #(.DEPTH(DEPTH), .MAX_RECORDS(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .stopPcEnable(stopPcEnable), .stopPc(stopPc), .pc(pc),
    .instruction(instruction), .regWriteData(regWriteData),
    .outValid(outValid), .outReady(outReady), .outRecord(outRecord),
    .busy(busy), .done(done), .overflow(overflow),
    .dropCount(dropCount), .recordCount(recordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] mkRec(input logic [31:0] p);
    return {p, ~p, p + 32'h100};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mState = 0;
      mRec   = 0;
      mDrop  = 0;
      mOvf   = 0;
    end else begin
      mPop  = (mq.size() != 0) && outReady;
      mRoom = (mq.size() < DEPTH) || mPop;
      if (mPop) begin
        drained.push_back(mq[0][95:64]);
        void'(mq.pop_front());
      end
      if (mState != 1) begin
        if (start) begin
          mState = 1;
          mRec   = 0;
          mDrop  = 0;
          mOvf   = 0;
        end
      end else begin
        if (mRoom) begin
          mq.push_back({pc, instruction, regWriteData});
          if (mRec < 65535) mRec++;
        end else begin
          mOvf = 1;
          if (mDrop < 65535) mDrop++;
        end
        if (stop || (stopPcEnable && pc == stopPc) || (mRoom && mRec == int'(MAXR)))
          mState = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("outValid", 96'(outValid), 96'(mq.size() != 0));
      if (mq.size() != 0) check("outRecord", outRecord, mq[0]);
      check("busy", 96'(busy), 96'(mState == 1));
      check("done", 96'(done), 96'(mState == 2));
      check("overflow", 96'(overflow), 96'(mOvf));
      check("dropCount", 96'(dropCount), 96'(16'(mDrop)));
      check("recordCount", 96'(recordCount), 96'(16'(mRec)));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setPc(input logic [31:0] p);
    pc           = p;
    instruction  = ~p;
    regWriteData = p + 32'h100;
  endtask

  task automatic startCapture(input logic [31:0] firstPc);
    start = 1'b1;
    setPc(32'hDEAD_0000);
    tick();
    start = 1'b0;
    setPc(firstPc);
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 4; i++) tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; stopPcEnable = 1'b0;
    stopPc = '0; outReady = 1'b0;
    setPc(32'h0);
    tick(); tick();
    check("rst outValid", 96'(outValid), 96'(0));
    check("rst outRecord", outRecord, 96'(0));
    check("rst busy", 96'(busy), 96'(0));
    check("rst done", 96'(done), 96'(0));
    check("rst counts", 96'({overflow, dropCount, recordCount}), 96'(0));
    reset = 1'b1;
    tick();

    // Auto-stop after MAXR accepted records with a ready consumer.
    drained.delete();
    outReady = 1'b1;
    startCapture(32'h0);
    check("A busy after start", 96'(busy), 96'(1));
    for (int k = 0; k < 60; k++) begin
      tick();
      if (k == 0) begin
        check("A first visible", 96'(outValid), 96'(1));
        check("A first record", outRecord, {32'h0, 32'hFFFF_FFFF, 32'h100});
      end
      setPc(pc + 32'd4);
      if (done) break;
    end
    check("A done", 96'(done), 96'(1));
    check("A recordCount", 96'(recordCount), 96'(20));
    check("A dropCount", 96'(dropCount), 96'(0));
    drain();
    check("A drained n", 96'(drained.size()), 96'(20));
    check("A first pc", 96'(drained[0]), 96'(32'h0));
    check("A last pc", 96'(drained[19]), 96'(32'd76));

    // Overflow: 20 attempts with no consumer, stop on the 20th.
    drained.delete();
    outReady = 1'b0;
    startCapture(32'h1000);
    for (int i = 0; i < 20; i++) begin
      if (i == 19) stop = 1'b1;
      tick();
      stop = 1'b0;
      setPc(pc + 32'd4);
    end
    check("B done", 96'(done), 96'(1));
    check("B recordCount", 96'(recordCount), 96'(16));
    check("B dropCount", 96'(dropCount), 96'(4));
    check("B overflow", 96'(overflow), 96'(1));
    check("B head", outRecord, mkRec(32'h1000));
    drain();
    check("B drained n", 96'(drained.size()), 96'(16));
    begin
      int errs = 0;
      for (int i = 0; i < 16; i++)
        if (drained[i] !== 32'h1000 + 32'(4 * i)) errs++;
      check("B order", 96'(errs), 96'(0));
    end
    check("B overflow sticky", 96'(overflow), 96'(1));

    // Full FIFO with a ready consumer: push and pop together, no drops.
    drained.delete();
    outReady = 1'b0;
    startCapture(32'h2000);
    for (int i = 0; i < 19; i++) begin
      if (i == 16) outReady = 1'b1;
      if (i == 18) stop = 1'b1;
      tick();
      stop = 1'b0;
      setPc(pc + 32'd4);
    end
    check("C done", 96'(done), 96'(1));
    check("C recordCount", 96'(recordCount), 96'(19));
    check("C dropCount", 96'(dropCount), 96'(0));
    check("C overflow", 96'(overflow), 96'(0));
    drain();
    check("C drained n", 96'(drained.size()), 96'(19));
    check("C first pc", 96'(drained[0]), 96'(32'h2000));
    check("C last pc", 96'(drained[18]), 96'(32'h2048));

    // PC-match stop.
    drained.delete();
    stopPcEnable = 1'b1;
    stopPc = 32'h10;
    outReady = 1'b1;
    startCapture(32'h0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) break;
      setPc(pc + 32'd4);
    end
    check("D done", 96'(done), 96'(1));
    check("D recordCount", 96'(recordCount), 96'(5));
    drain();
    stopPcEnable = 1'b0;
    check("D drained n", 96'(drained.size()), 96'(5));
    check("D last pc", 96'(drained[drained.size() - 1]), 96'(32'h10));

    // Asynchronous reset with records queued.
    drained.delete();
    outReady = 1'b0;
    startCapture(32'h3000);
    for (int i = 0; i < 5; i++) begin
      tick();
      setPc(pc + 32'd4);
    end
    check("E queued", 96'(recordCount), 96'(5));
    #2;
    reset = 1'b0;
    #1;
    check("E rst outValid", 96'(outValid), 96'(0));
    check("E rst counts", 96'({overflow, dropCount, recordCount}), 96'(0));
    check("E rst busy", 96'(busy), 96'(0));
    tick(); tick();
    reset = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      setPc(pc + 32'd4);
    end
    check("E idle busy", 96'(busy), 96'(0));
    check("E idle outValid", 96'(outValid), 96'(0));
    check("E idle recordCount", 96'(recordCount), 96'(0));

    // Start and stop in the same idle cycle: start wins.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    setPc(32'h4000);
    check("F busy", 96'(busy), 96'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      setPc(pc + 32'd4);
    end
    check("F still busy", 96'(busy), 96'(1));
    check("F recordCount", 96'(recordCount), 96'(3));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("F done", 96'(done), 96'(1));
    check("F final count", 96'(recordCount), 96'(4));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
